// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection traffic phase controller.
// Light index order is north, east, south, west.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN = 3'd0,
    NS_CLEAR = 3'd1,
    EW_GREEN = 3'd2,
    EW_CLEAR = 3'd3,
    HOLD     = 3'd4
  } phase_e;

  localparam logic [3:0] GREEN_NS   = 4'b0101;
  localparam logic [3:0] GREEN_EW   = 4'b1010;
  localparam logic [3:0] GREEN_NONE = 4'b0000;

  localparam int unsigned N = 0;
  localparam int unsigned E = 1;
  localparam int unsigned S = 2;
  localparam int unsigned W = 3;

  function automatic logic [3:0] green_mask(input phase_e p);
    logic [3:0] m;
    m = GREEN_NONE;
    if (p == NS_GREEN) m = GREEN_NS;
    if (p == EW_GREEN) m = GREEN_EW;
    return m;
  endfunction

  function automatic logic is_green(input phase_e p);
    return (p == NS_GREEN) || (p == EW_GREEN);
  endfunction

endpackage

// File: rtl/tick_timer.sv
// Saturating tick counter, cleared on state entry.
// Clear takes priority over a same-cycle tick.
module tick_timer #(
  parameter int unsigned TIMER_W = 6
) (
  input  logic               dclk,
  input  logic               clr_n,
  input  logic               clear,
  input  logic               tick,
  output logic [TIMER_W-1:0] count
);

  localparam logic [TIMER_W-1:0] SAT = '1;
  localparam logic [TIMER_W-1:0] ONE = TIMER_W'(1);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (tick && (count_q != SAT)) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge dclk) begin
    if (!clr_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/traffic_phase_controller.sv
// Actuated NS/EW traffic phase sequencer with all-red clearance and halt.
// Outputs are registered from next-state so lights change with the state.
module traffic_phase_controller
  import traffic_pkg::*;
#(
  parameter int unsigned TIMER_W     = 6,
  parameter int unsigned MIN_GREEN   = 3,
  parameter int unsigned NOM_GREEN   = 8,
  parameter int unsigned MAX_GREEN   = 16,
  parameter int unsigned CLEAR_TICKS = 2
) (
  input  logic               dclk,
  input  logic               clr_n,
  input  logic               tick,
  input  logic [3:0]         sensor,
  input  logic               force_change,
  input  logic               halt,
  output logic [3:0]         green,
  output logic               all_red,
  output logic [2:0]         phase,
  output logic               phase_change,
  output logic [TIMER_W-1:0] timer
);

  localparam int unsigned TMAX = (1 << TIMER_W) - 1;

  if ((MIN_GREEN < 1) || (MIN_GREEN > NOM_GREEN) ||
      (NOM_GREEN > MAX_GREEN) || (MAX_GREEN > TMAX) ||
      (CLEAR_TICKS < 1)) begin : g_bad_cfg
    $error("traffic_phase_controller: illegal timing parameters");
  end

  localparam logic [TIMER_W:0] MIN_E = (TIMER_W + 1)'(MIN_GREEN);
  localparam logic [TIMER_W:0] NOM_E = (TIMER_W + 1)'(NOM_GREEN);
  localparam logic [TIMER_W:0] MAX_E = (TIMER_W + 1)'(MAX_GREEN);
  localparam logic [TIMER_W:0] CLR_E = (TIMER_W + 1)'(CLEAR_TICKS);
  localparam logic [TIMER_W:0] ONE_E = (TIMER_W + 1)'(1);

  phase_e             state_q, state_d;
  logic [3:0]         demand_q, demand_d;
  logic               force_q, force_d;
  logic [3:0]         green_q, green_d;
  logic               all_red_q, all_red_d;
  logic               pchg_q, pchg_d;
  logic [TIMER_W-1:0] timer_q;
  logic [TIMER_W:0]   elapsed;
  logic               opp_dem;
  logic               clr_done;
  logic               grn_done;
  logic               changed;

  tick_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .dclk  (dclk),
    .clr_n (clr_n),
    .clear (changed),
    .tick  (tick),
    .count (timer_q)
  );

  always_comb begin
    elapsed = {1'b0, timer_q} + ONE_E;
    opp_dem = (state_q == NS_GREEN) ?
              (demand_q[E] | demand_q[W]) :
              (demand_q[N] | demand_q[S]);
    clr_done = tick && (elapsed == CLR_E);
    grn_done = tick && ((elapsed >= MAX_E) ||
               ((elapsed >= NOM_E) && opp_dem) ||
               ((elapsed >= MIN_E) && force_q));
  end

  always_comb begin
    state_d = state_q;
    if (halt) begin
      state_d = HOLD;
    end else begin
      unique case (state_q)
        NS_GREEN: if (grn_done) state_d = NS_CLEAR;
        NS_CLEAR: if (clr_done) state_d = EW_GREEN;
        EW_GREEN: if (grn_done) state_d = EW_CLEAR;
        EW_CLEAR: if (clr_done) state_d = NS_GREEN;
        HOLD:     state_d = EW_CLEAR;
        default:  state_d = EW_CLEAR;
      endcase
    end
  end

  always_comb begin
    changed  = (state_d != state_q);
    demand_d = demand_q | sensor;
    // Serving a direction discards any request that arrives on entry.
    if (changed && (state_d == NS_GREEN)) begin
      demand_d[N] = 1'b0;
      demand_d[S] = 1'b0;
    end
    if (changed && (state_d == EW_GREEN)) begin
      demand_d[E] = 1'b0;
      demand_d[W] = 1'b0;
    end
    force_d = 1'b0;
    if (!changed && is_green(state_q)) begin
      force_d = force_q | force_change;
    end
    green_d   = green_mask(state_d);
    all_red_d = (green_d == GREEN_NONE);
    pchg_d    = changed;
  end

  always_ff @(posedge dclk) begin
    if (!clr_n) begin
      state_q   <= EW_CLEAR;
      demand_q  <= 4'b0000;
      force_q   <= 1'b0;
      green_q   <= GREEN_NONE;
      all_red_q <= 1'b1;
      pchg_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      demand_q  <= demand_d;
      force_q   <= force_d;
      green_q   <= green_d;
      all_red_q <= all_red_d;
      pchg_q    <= pchg_d;
    end
  end

  assign green        = green_q;
  assign all_red      = all_red_q;
  assign phase        = state_q;
  assign phase_change = pchg_q;
  assign timer        = timer_q;

endmodule
